// File: rtl/ras_ctrl.sv
// Return-address-stack speculation controller: issues frontend call/return ops
// to the RAS one cycle after acceptance and tracks per-stage op counts for commit/flush.
//
// state   | meaning
// RESET   | first cycle after reset release, no requests accepted
// RUN     | normal operation, requests accepted when there is room
// RECOVER | one cycle after a kill, requests held off
module ras_ctrl #(
  parameter int STAGES       = 2,
  parameter int WIDTH        = 31,
  parameter int MAX_BRANCHES = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_call,
  input  logic              req_ret,
  input  logic [WIDTH-1:0]  req_addr,
  input  logic [STAGES-1:0] adv,
  output logic [STAGES-1:0] adv_ready,
  input  logic [STAGES-1:0] kill,
  output logic              ras_push,
  output logic              ras_pop,
  output logic [WIDTH-1:0]  ras_din,
  output logic [STAGES-1:0] commit,
  output logic [STAGES-1:0] flush,
  output logic              busy
);

  localparam int CW  = $clog2(MAX_BRANCHES + 1);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_RECOVER
  } state_t;

  state_t                       state;
  logic [STAGES-1:0][CW-1:0]    cnt;
  logic [STAGES-1:0][CW:0]      cnt_nxt;
  logic                         iss_valid;
  logic                         iss_push;
  logic                         iss_pop;
  logic [WIDTH-1:0]             iss_addr;
  logic [STAGES-1:0]            sup;
  logic                         kill_any;
  logic                         accept;
  logic                         issue;

  // Thermometer of the highest kill bit: stages at or below it are discarded.
  always_comb begin
    sup = '0;
    for (int i = 0; i < STAGES; i++) begin
      sup[i] = |(kill >> i);
    end
  end

  assign kill_any  = |kill;
  assign req_ready = (state == S_RUN) && !kill_any &&
                     ((CW1'(cnt[0]) + CW1'(iss_valid)) < CW1'(MAX_BRANCHES));
  assign accept    = req_valid && req_ready;
  assign issue     = iss_valid && !kill_any;

  assign ras_push  = issue && iss_push;
  assign ras_pop   = issue && iss_pop;
  assign ras_din   = iss_addr;

  assign flush     = sup & {STAGES{~rst_i}};
  assign commit    = adv & adv_ready & ~sup & {STAGES{~rst_i}};
  assign busy      = (state == S_RECOVER) || (|cnt);

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [CW:0] keep;
    logic [CW:0] inc;

    if (g == STAGES - 1) begin : g_last
      assign adv_ready[g] = 1'b1;
    end else begin : g_mid
      assign adv_ready[g] = (CW1'(cnt[g]) + CW1'(cnt[g+1])) <= CW1'(MAX_BRANCHES);
    end

    if (g == 0) begin : g_head
      assign inc = CW1'(issue);
    end else begin : g_tail
      assign inc = commit[g-1] ? CW1'(cnt[g-1]) : '0;
    end

    // All commits read pre-cycle counts, so a commit chain shifts every group one stage.
    assign keep       = commit[g] ? '0 : CW1'(cnt[g]);
    assign cnt_nxt[g] = sup[g] ? '0 : keep + inc;

    a_no_wrap: assert property (@(posedge clk) disable iff (rst_i)
                                cnt_nxt[g] <= CW1'(MAX_BRANCHES));
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_RESET;
      cnt       <= '0;
      iss_valid <= 1'b0;
      iss_push  <= 1'b0;
      iss_pop   <= 1'b0;
      iss_addr  <= '0;
    end else begin
      case (state)
        S_RESET:   state <= S_RUN;
        S_RUN:     if (kill_any) state <= S_RECOVER;
        S_RECOVER: if (!kill_any) state <= S_RUN;
        default:   state <= S_RESET;
      endcase

      for (int i = 0; i < STAGES; i++) begin
        cnt[i] <= cnt_nxt[i][CW-1:0];
      end

      // The issue register always drains after one cycle; a kill can never coincide with accept.
      iss_valid <= accept && (req_call || req_ret);
      if (accept && (req_call || req_ret)) begin
        iss_push <= req_call;
        iss_pop  <= req_ret;
        iss_addr <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue/arithmetic model of the controller.
module tb_ras_ctrl;

  logic        clk;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_call;
  logic        req_ret;
  logic [30:0] req_addr;
  logic [1:0]  adv;
  logic [1:0]  adv_ready;
  logic [1:0]  kill;
  logic        ras_push;
  logic        ras_pop;
  logic [30:0] ras_din;
  logic [1:0]  commit;
  logic [1:0]  flush;
  logic        busy;

  ras_ctrl #(.STAGES(2), .WIDTH(31), .MAX_BRANCHES(16)) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_call(req_call), .req_ret(req_ret), .req_addr(req_addr),
    .adv(adv), .adv_ready(adv_ready), .kill(kill),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_din(ras_din),
    .commit(commit), .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          push;
    bit          pop;
    logic [30:0] addr;
  } op_t;

  // Model: ops waiting in the issue slot, per-stage op counts, and the phase flags.
  op_t  pend[$];
  int   m_cnt[2];
  bit   m_started;
  bit   m_recover;
  logic [1:0] e_commit;
  bit   e_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int kill_top();
    if (kill[1]) return 1;
    if (kill[0]) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    m_cnt[0]  = 0;
    m_cnt[1]  = 0;
    m_started = 0;
    m_recover = 0;
    pend.delete();
  endtask

  task automatic compare_outputs();
    int kt;
    logic [1:0] e_flush;
    logic [1:0] e_ar;
    bit e_push, e_pop, e_busy;
    kt = kill_top();
    for (int j = 0; j < 2; j++) e_flush[j] = (j <= kt);
    e_ar[0] = (m_cnt[0] + m_cnt[1] <= 16);
    e_ar[1] = 1'b1;
    for (int i = 0; i < 2; i++) e_commit[i] = adv[i] && e_ar[i] && (i > kt);
    e_ready = m_started && !m_recover && (kill == 2'b00) && (m_cnt[0] + pend.size() < 16);
    e_push  = (pend.size() > 0) && (kill == 2'b00) && pend[0].push;
    e_pop   = (pend.size() > 0) && (kill == 2'b00) && pend[0].pop;
    e_busy  = m_recover || (m_cnt[0] != 0) || (m_cnt[1] != 0);
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("adv_ready", 32'(adv_ready), 32'(e_ar));
    chk("commit", 32'(commit), 32'(e_commit));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("ras_push", 32'(ras_push), 32'(e_push));
    chk("ras_pop", 32'(ras_pop), 32'(e_pop));
    chk("busy", 32'(busy), 32'(e_busy));
    if (e_push) chk("ras_din", 32'(ras_din), 32'(pend[0].addr));
  endtask

  task automatic model_update();
    int  kt, n0, n1;
    bit  issued;
    op_t o;
    kt     = kill_top();
    issued = (pend.size() > 0) && (kill == 2'b00);
    n0 = e_commit[0] ? 0 : m_cnt[0];
    n1 = e_commit[1] ? 0 : m_cnt[1];
    if (e_commit[0]) n1 += m_cnt[0];
    if (issued) n0 += 1;
    if (kt >= 0) n0 = 0;
    if (kt >= 1) n1 = 0;
    m_cnt[0] = n0;
    m_cnt[1] = n1;
    pend.delete();
    if (req_valid && e_ready && (req_call || req_ret)) begin
      o.push = req_call;
      o.pop  = req_ret;
      o.addr = req_addr;
      pend.push_back(o);
    end
    if (!m_started) m_started = 1;
    else m_recover = (kill != 2'b00);
  endtask

  // Called at a falling edge: set inputs, let them settle, compare.
  task automatic drive(input logic v, input logic c, input logic r,
                       input logic [30:0] a, input logic [1:0] ad, input logic [1:0] k);
    req_valid = v;
    req_call  = c;
    req_ret   = r;
    req_addr  = a;
    adv       = ad;
    kill      = k;
    #2;
    compare_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    tick();
  endtask

  task automatic call_cycle(input logic [30:0] a);
    drive(1'b1, 1'b1, 1'b0, a, 2'b00, 2'b00);
    tick();
  endtask

  // Asserts reset mid-cycle with busy-looking inputs and checks outputs drop at once.
  task automatic apply_reset();
    req_valid = 1'b1;
    req_call  = 1'b1;
    req_ret   = 1'b1;
    req_addr  = 31'h155;
    adv       = 2'b11;
    kill      = 2'b01;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ras_push", 32'(ras_push), 32'd0);
    chk("rst_ras_pop", 32'(ras_pop), 32'd0);
    chk("rst_ras_din", 32'(ras_din), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    req_valid = 1'b0;
    req_call  = 1'b0;
    req_ret   = 1'b0;
    adv       = 2'b00;
    kill      = 2'b00;
  endtask

  task automatic random_cycle();
    logic [1:0] k, a;
    k = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    a[0] = ($urandom_range(0, 9) < 3);
    a[1] = ($urandom_range(0, 9) < 4);
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          31'($urandom), a, k);
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid = 1'b0; req_call = 1'b0; req_ret = 1'b0; req_addr = '0;
    adv = '0; kill = '0;
    model_reset();
    @(negedge clk);

    // Call at t, RAS push with its address at t+1, then one op counted in stage 0.
    apply_reset();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("reset_state_ready", 32'(req_ready), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 31'h1234, 2'b00, 2'b00);
    chk("call_ready", 32'(req_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("call_push", 32'(ras_push), 32'd1);
    chk("call_din", 32'(ras_din), 32'h1234);
    chk("call_pop", 32'(ras_pop), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("call_busy", 32'(busy), 32'd1);
    tick();
    // A request with neither call nor ret issues nothing.
    drive(1'b1, 1'b0, 1'b0, 31'h77, 2'b00, 2'b00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("nop_push", 32'(ras_push), 32'd0);
    chk("nop_pop", 32'(ras_pop), 32'd0);
    tick();

    // Sixteen calls fill stage 0; one advance reopens the request port.
    apply_reset();
    idle_cycle();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 31'(i + 100), 2'b00, 2'b00);
      chk("fill_ready", 32'(req_ready), 32'd1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 31'd5, 2'b00, 2'b00);
    chk("full_ready_a", 32'(req_ready), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 31'd5, 2'b00, 2'b00);
    chk("full_ready_b", 32'(req_ready), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b01, 2'b00);
    chk("full_commit", 32'(commit), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("reopen_ready", 32'(req_ready), 32'd1);
    tick();

    // cnt0=3, cnt1=2, adv=11 commits both stages.
    apply_reset();
    idle_cycle();
    call_cycle(31'h1); call_cycle(31'h2); idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b01, 2'b00);
    tick();
    call_cycle(31'h3); call_cycle(31'h4); call_cycle(31'h5); idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b11, 2'b00);
    chk("chain_commit", 32'(commit), 32'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b10, 2'b00);
    chk("chain_commit1", 32'(commit), 32'd2);
    chk("chain_busy", 32'(busy), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("chain_idle_busy", 32'(busy), 32'd0);
    tick();

    // kill=10 with a call in the issue register.
    apply_reset();
    idle_cycle();
    call_cycle(31'h4321);
    drive(1'b1, 1'b1, 1'b0, 31'h9, 2'b00, 2'b10);
    chk("kill_flush", 32'(flush), 32'd3);
    chk("kill_push", 32'(ras_push), 32'd0);
    chk("kill_ready", 32'(req_ready), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("recover_ready", 32'(req_ready), 32'd0);
    chk("recover_busy", 32'(busy), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("after_kill_ready", 32'(req_ready), 32'd1);
    chk("after_kill_busy", 32'(busy), 32'd0);
    tick();

    // kill=01 alongside adv=10: stage 1 still retires.
    apply_reset();
    idle_cycle();
    call_cycle(31'h11); idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b01, 2'b00);
    tick();
    call_cycle(31'h22); idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b10, 2'b01);
    chk("k01_flush", 32'(flush), 32'd1);
    chk("k01_commit", 32'(commit), 32'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("k01_recover_busy", 32'(busy), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
    chk("k01_retired_busy", 32'(busy), 32'd0);
    tick();

    // Randomized traffic with a reset pulse in the middle.
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
        chk("midrst_ready0", 32'(req_ready), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 31'd0, 2'b00, 2'b00);
        chk("midrst_ready1", 32'(req_ready), 32'd1);
        tick();
      end
      random_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
